fc_result_collector: RTL and testbench

//  Downstream end of the fully-connected accumulator (acc_sum).
//  - Captures each finished neuron sum on acc_done; adds a per-neuron bias.
//  - Applies optional ReLU, arithmetic-shift requantisation and saturation.
//  - Buffers results in a small FIFO and presents them on a valid/ready port to the next layer or writeback.
//  - acc_sum cannot be stalled, so this block absorbs back-pressure and flags any dropped results.

---
 rtl/fc_result_collector.sv | 136 +++++++++++++
 tb/tb_fc_result_collector.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_collector.sv
// Downstream end of the fully-connected accumulator: bias add, ReLU, requantise and saturate,
// then a first-word-fall-through FIFO that absorbs back-pressure and flags dropped results.
module fc_result_collector #(
   parameter int gen_width   = 21,
   parameter int OUT_W       = 8,
   parameter int SHIFT       = 6,
   parameter int NUM_NEURONS = 16,
   parameter int IDX_W       = 4,
   parameter int DEPTH       = 4,
   parameter bit RELU_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clr,
   input  logic                 acc_done,
   input  logic [gen_width-1:0] acc_result,
   output logic [IDX_W-1:0]     bias_idx,
   input  logic [gen_width-1:0] bias_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_W-1:0]     out_data,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 layer_done,
   output logic                 ovf
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
   localparam int SAT_MIN_I = -(1 << (OUT_W - 1));
   localparam logic signed [gen_width:0] SAT_MAX = SAT_MAX_I[gen_width:0];
   localparam logic signed [gen_width:0] SAT_MIN = SAT_MIN_I[gen_width:0];

   logic [IDX_W-1:0]        neuron_cnt;
   logic signed [gen_width:0] s1_sum;
   logic signed [gen_width:0] sum_next;
   logic [IDX_W-1:0]        s1_idx;
   logic                    s1_vld;

   logic signed [gen_width:0] relu_v;
   logic signed [gen_width:0] shr_v;
   logic [OUT_W-1:0]        q_sat;

   logic [OUT_W-1:0]        mem_data [DEPTH];
   logic [IDX_W-1:0]        mem_idx  [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;
   logic                    push;
   logic                    pop;
   logic                    full;
   logic                    do_write;
   logic                    drop;

   // One extra bit keeps the sum of two full-range signed operands exact.
   assign sum_next = $signed({acc_result[gen_width-1], acc_result})
                   + $signed({bias_data[gen_width-1], bias_data});

   // Stage 1: capture the finished sum with its bias and tag it with the neuron index.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rstn) begin
         neuron_cnt <= '0;
         s1_vld     <= 1'b0;
         s1_sum     <= '0;
         s1_idx     <= '0;
      end else if (clr) begin
         neuron_cnt <= '0;
         s1_vld     <= 1'b0;
      end else begin
         s1_vld <= acc_done;
         if (acc_done) begin
            s1_sum     <= sum_next;
            s1_idx     <= neuron_cnt;
            neuron_cnt <= (neuron_cnt == LAST_IDX) ? '0 : neuron_cnt + 1'b1;
         end
      end
   end

   // Stage 2: ReLU, arithmetic shift (floor), then clamp into the signed output range.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no latch is inferred.
      relu_v = s1_sum;
      q_sat  = shr_v[OUT_W-1:0];
      if (RELU_EN && s1_sum[gen_width]) relu_v = '0;
      if (shr_v > SAT_MAX)      q_sat = SAT_MAX[OUT_W-1:0];
      else if (shr_v < SAT_MIN) q_sat = SAT_MIN[OUT_W-1:0];
   end

   assign shr_v = relu_v >>> SHIFT;

   assign push     = s1_vld;
   assign pop      = out_valid & out_ready;
   assign full     = (count == CNT_W'(DEPTH));
   // A pop frees the head slot in the same edge, so a full FIFO still accepts a push.
   assign do_write = push & (~full | pop);
   assign drop     = push & full & ~pop;

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: the buffer is reset too, since out_data shows the head entry and must read 0 after reset.
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_idx[i]  <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_write) begin
            mem_data[wr_ptr] <= q_sat;
            mem_idx[wr_ptr]  <= s1_idx;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_write && !pop)      count <= count + 1'b1;
         else if (!do_write && pop) count <= count - 1'b1;
         if (drop) ovf <= 1'b1;
      end
   end

   assign bias_idx   = neuron_cnt;
   assign out_valid  = (count != '0);
   assign out_data   = mem_data[rd_ptr];
   assign out_idx    = mem_idx[rd_ptr];
   // Fires whether the last neuron's result is kept or dropped; a clear suppresses it.
   assign layer_done = s1_vld & (s1_idx == LAST_IDX) & ~clr;

endmodule

// File: tb/tb_fc_result_collector.sv
// Bench for fc_result_collector: two instances (ReLU on / off) share stimulus and are checked
// against a queue-based reference model plus constants taken from the block's arithmetic rules.
module tb_fc_result_collector;

   localparam int GW    = 21;
   localparam int OW    = 8;
   localparam int SH    = 6;
   localparam int NN    = 16;
   localparam int IW    = 4;
   localparam int DEPTH = 4;
   localparam int DIV   = 1 << SH;

   logic          clk = 1'b0;
   logic          rstn;
   logic          clr;
   logic          acc_done;
   logic          out_ready;
   logic [GW-1:0] acc_result;
   logic [GW-1:0] bias_data;
   logic [IW-1:0] bias_idx_a, bias_idx_b, out_idx_a, out_idx_b;
   logic [OW-1:0] out_data_a, out_data_b;
   logic          out_valid_a, out_valid_b, layer_done_a, layer_done_b, ovf_a, ovf_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: results waiting for the consumer, one in-flight capture, counter, ovf.
   int q_sum[$];
   int q_idx[$];
   bit p_vld;
   int p_sum;
   int p_idx;
   int m_cnt;
   bit m_ovf;

   always #5 clk = ~clk;

   fc_result_collector #(.gen_width(GW), .OUT_W(OW), .SHIFT(SH), .NUM_NEURONS(NN), .IDX_W(IW),
                         .DEPTH(DEPTH), .RELU_EN(1'b1)) dut_a (
      .clk(clk), .rstn(rstn), .clr(clr), .acc_done(acc_done), .acc_result(acc_result),
      .bias_idx(bias_idx_a), .bias_data(bias_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_idx(out_idx_a), .layer_done(layer_done_a), .ovf(ovf_a));

   fc_result_collector #(.gen_width(GW), .OUT_W(OW), .SHIFT(SH), .NUM_NEURONS(NN), .IDX_W(IW),
                         .DEPTH(DEPTH), .RELU_EN(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .clr(clr), .acc_done(acc_done), .acc_result(acc_result),
      .bias_idx(bias_idx_b), .bias_data(bias_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_idx(out_idx_b), .layer_done(layer_done_b), .ovf(ovf_b));

   function automatic int sx(input logic [GW-1:0] x);
      return int'($signed(x));
   endfunction

   // Floor division by 2^SHIFT, optional ReLU first, then clamp to the signed OUT_W range.
   function automatic int quant(input int s, input bit relu);
      int v;
      int q;
      v = (relu && s < 0) ? 0 : s;
      if (v >= 0) q = v / DIV;
      else        q = -((-v + DIV - 1) / DIV);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   function automatic bit m_valid();
      return q_sum.size() != 0;
   endfunction

   function automatic bit m_layer();
      return rstn && !clr && p_vld && (p_idx == NN - 1);
   endfunction

   task automatic model_reset();
      q_sum.delete();
      q_idx.delete();
      p_vld = 1'b0;
      p_sum = 0;
      p_idx = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endtask

   // Applies the inputs held during the cycle that just ended.
   task automatic model_edge();
      if (!rstn || clr) begin
         model_reset();
         return;
      end
      if (q_sum.size() != 0 && out_ready) begin
         void'(q_sum.pop_front());
         void'(q_idx.pop_front());
      end
      if (p_vld) begin
         if (q_sum.size() == DEPTH) m_ovf = 1'b1;
         else begin
            q_sum.push_back(p_sum);
            q_idx.push_back(p_idx);
         end
      end
      p_vld = acc_done;
      if (acc_done) begin
         p_sum = sx(acc_result) + sx(bias_data);
         p_idx = m_cnt;
         m_cnt = (m_cnt + 1) % NN;
      end
   endtask

   // One clock cycle: commit the previous inputs to the model, drive new inputs at the falling edge.
   task automatic step(input bit d, input int r, input int b, input bit rdy, input bit c);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      acc_done   = d;
      acc_result = r[GW-1:0];
      bias_data  = b[GW-1:0];
      out_ready  = rdy;
      clr        = c;
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({out_valid_a, out_data_a, out_idx_a, bias_idx_a, layer_done_a, ovf_a} !== '0 ||
          {out_valid_b, out_data_b, out_idx_b, bias_idx_b, layer_done_b, ovf_b} !== '0) begin
         n_errors++;
         $display("FAIL reset_state valid=%b data=%0d idx=%0d bias_idx=%0d layer_done=%b ovf=%b, required all 0",
                  out_valid_a, out_data_a, out_idx_a, bias_idx_a, layer_done_a, ovf_a);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) step(k < 3, 1000 * (k + 1), 0, 1'b0, 1'b0);
      n_checks++;
      if (out_valid_a !== 1'b1 || q_sum.size() != 3) begin
         n_errors++;
         $display("FAIL reset_prefill valid=%b model_count=%0d, required 1 and 3", out_valid_a, q_sum.size());
      end
      @(negedge clk);
      rstn     = 1'b0;
      acc_done = 1'b1;
      #1;
      n_checks++;
      if ({out_valid_a, out_data_a, out_idx_a, bias_idx_a, layer_done_a, ovf_a} !== '0 ||
          {out_valid_b, out_data_b, out_idx_b, bias_idx_b, layer_done_b, ovf_b} !== '0) begin
         n_errors++;
         $display("FAIL midstream_reset valid=%b data=%0d idx=%0d bias_idx=%0d layer_done=%b ovf=%b, required all 0",
                  out_valid_a, out_data_a, out_idx_a, bias_idx_a, layer_done_a, ovf_a);
      end
      model_reset();
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid_a !== 1'b0 || bias_idx_a !== '0) begin
         n_errors++;
         $display("FAIL reset_held valid=%b bias_idx=%0d, required 0 and 0", out_valid_a, bias_idx_a);
      end
      @(negedge clk);
      rstn     = 1'b1;
      acc_done = 1'b0;
      step(1'b1, 2048, 64, 1'b1, 1'b0);
      n_checks++;
      if (bias_idx_a !== 4'd0) begin
         n_errors++;
         $display("FAIL first_idx_after_reset got %0d required 0", bias_idx_a);
      end
      step(1'b0, 0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid_a !== 1'b1 || out_idx_a !== 4'd0 || int'($signed(out_data_a)) != 33) begin
         n_errors++;
         $display("FAIL first_result_after_reset valid=%b idx=%0d data=%0d, required 1/0/33",
                  out_valid_a, out_idx_a, $signed(out_data_a));
      end
   endtask

   task automatic test_arith();
      int tr[5] = '{1000, -500, 100000, -100000, -65};
      int tb[5] = '{24, 0, 0, 0, 0};
      int ea[5] = '{16, 0, 127, 0, 0};
      int eb[5] = '{16, -8, 127, -128, -2};
      step(1'b0, 0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, tr[i], tb[i], 1'b1, 1'b0);
         step(1'b0, 0, 0, 1'b1, 1'b0);
         step(1'b0, 0, 0, 1'b1, 1'b0);
         n_checks++;
         if (out_valid_a !== 1'b1 || int'($signed(out_data_a)) != ea[i] || int'($signed(out_data_b)) != eb[i]) begin
            n_errors++;
            $display("FAIL arith case=%0d valid=%b relu_data=%0d plain_data=%0d, required 1/%0d/%0d",
                     i, out_valid_a, $signed(out_data_a), $signed(out_data_b), ea[i], eb[i]);
         end
      end
      for (int k = 0; k < 60; k++) begin
         step(1'($urandom_range(0, 1)), (k % 2) ? int'($urandom) : int'($urandom_range(0, 8191)) - 4096,
              int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 1)), 1'b0);
         n_checks++;
         if (out_valid_a !== m_valid() || out_valid_b !== m_valid()) begin
            n_errors++;
            $display("FAIL random_valid k=%0d got %b/%b required %b", k, out_valid_a, out_valid_b, m_valid());
         end
         if (m_valid()) begin
            n_checks++;
            if (out_idx_a !== q_idx[0] || int'($signed(out_data_a)) != quant(q_sum[0], 1'b1) ||
                int'($signed(out_data_b)) != quant(q_sum[0], 1'b0)) begin
               n_errors++;
               $display("FAIL random_head k=%0d idx=%0d data=%0d/%0d, required %0d %0d/%0d", k, out_idx_a,
                        $signed(out_data_a), $signed(out_data_b), q_idx[0], quant(q_sum[0], 1'b1), quant(q_sum[0], 1'b0));
            end
         end
         n_checks++;
         if (ovf_a !== m_ovf || layer_done_a !== m_layer() || bias_idx_a !== m_cnt[IW-1:0]) begin
            n_errors++;
            $display("FAIL random_status k=%0d ovf=%b layer_done=%b bias_idx=%0d, required %b %b %0d",
                     k, ovf_a, layer_done_a, bias_idx_a, m_ovf, m_layer(), m_cnt);
         end
      end
   endtask

   task automatic test_stream();
      bit exp_v;
      step(1'b0, 0, 0, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++) begin
         step(k < 16, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)), 1'b1, 1'b0);
         exp_v = (k >= 2 && k < 18);
         n_checks++;
         if (out_valid_a !== exp_v || (exp_v && out_idx_a !== 4'(k - 2))) begin
            n_errors++;
            $display("FAIL stream_order k=%0d valid=%b idx=%0d, required %b idx %0d", k, out_valid_a, out_idx_a, exp_v, k - 2);
         end
         if (exp_v && m_valid()) begin
            n_checks++;
            if (int'($signed(out_data_a)) != quant(q_sum[0], 1'b1)) begin
               n_errors++;
               $display("FAIL stream_data k=%0d got %0d required %0d", k, $signed(out_data_a), quant(q_sum[0], 1'b1));
            end
         end
         n_checks++;
         if (layer_done_a !== (k == 16) || layer_done_b !== (k == 16) || bias_idx_a !== 4'(k < 16 ? k : 0)) begin
            n_errors++;
            $display("FAIL stream_layer k=%0d layer_done=%b bias_idx=%0d, required %b %0d",
                     k, layer_done_a, bias_idx_a, (k == 16), (k < 16 ? k : 0));
         end
      end
   endtask

   task automatic test_back_pressure();
      int s0 = 0;
      step(1'b0, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(k < 6, int'($urandom_range(0, 16383)) - 4096, int'($urandom_range(0, 511)), 1'b0, 1'b0);
         if (k == 0) s0 = sx(acc_result) + sx(bias_data);
         n_checks++;
         if (out_valid_a !== (k >= 2) || ovf_a !== (k >= 6) || ovf_b !== (k >= 6)) begin
            n_errors++;
            $display("FAIL bp_status k=%0d valid=%b ovf=%b, required %b %b", k, out_valid_a, ovf_a, (k >= 2), (k >= 6));
         end
         if (k >= 2) begin
            n_checks++;
            if (out_idx_a !== 4'd0 || int'($signed(out_data_a)) != quant(s0, 1'b1) ||
                int'($signed(out_data_b)) != quant(s0, 1'b0)) begin
               n_errors++;
               $display("FAIL bp_hold k=%0d idx=%0d data=%0d/%0d, required 0 %0d/%0d", k, out_idx_a,
                        $signed(out_data_a), $signed(out_data_b), quant(s0, 1'b1), quant(s0, 1'b0));
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 0, 0, 1'b1, 1'b0);
         n_checks++;
         if (out_valid_a !== (k < 4) || (k < 4 && out_idx_a !== 4'(k)) || ovf_a !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_drain k=%0d valid=%b idx=%0d ovf=%b, required %b %0d 1", k, out_valid_a, out_idx_a, ovf_a, (k < 4), k);
         end
      end
   endtask

   task automatic test_clr();
      int n;
      n_checks++;
      if (ovf_a !== m_ovf || m_ovf !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_pre_ovf got %b required 1", ovf_a);
      end
      n = (13 - m_cnt + NN) % NN;
      for (int i = 0; i < n; i++) step(1'b1, int'($urandom_range(0, 4095)), 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 640, 0, 1'b0, 1'b0);
      step(1'b1, 640, 0, 1'b0, 1'b1);
      n_checks++;
      if (layer_done_a !== 1'b0 || layer_done_b !== 1'b0 || out_valid_a !== 1'b1 || q_sum.size() != 2) begin
         n_errors++;
         $display("FAIL clr_cycle layer_done=%b valid=%b model_count=%0d, required 0 1 2",
                  layer_done_a, out_valid_a, q_sum.size());
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 0, 0, 1'b1, 1'b0);
         n_checks++;
         if (out_valid_a !== 1'b0 || ovf_a !== 1'b0 || bias_idx_a !== 4'd0 || layer_done_a !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_after k=%0d valid=%b ovf=%b bias_idx=%0d layer_done=%b, required 0 0 0 0",
                     k, out_valid_a, ovf_a, bias_idx_a, layer_done_a);
         end
      end
      step(1'b1, 640, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid_a !== 1'b1 || out_idx_a !== 4'd0 || int'($signed(out_data_a)) != 10) begin
         n_errors++;
         $display("FAIL clr_restart valid=%b idx=%0d data=%0d, required 1 0 10", out_valid_a, out_idx_a, $signed(out_data_a));
      end
   endtask

   task automatic test_full_pushpop();
      step(1'b0, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 25; k++) begin
         step(k < 15, int'($urandom_range(0, 8191)), 0, k >= 5, 1'b0);
         n_checks++;
         if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || out_valid_a !== m_valid() || (k >= 5 && k <= 16 && out_valid_a !== 1'b1)) begin
            n_errors++;
            $display("FAIL full_status k=%0d ovf=%b valid=%b, required 0 %b", k, ovf_a, out_valid_a, m_valid());
         end
         if (m_valid()) begin
            n_checks++;
            if (out_idx_a !== q_idx[0] || int'($signed(out_data_a)) != quant(q_sum[0], 1'b1)) begin
               n_errors++;
               $display("FAIL full_head k=%0d idx=%0d data=%0d, required %0d %0d",
                        k, out_idx_a, $signed(out_data_a), q_idx[0], quant(q_sum[0], 1'b1));
            end
         end
      end
   endtask

   initial begin
      rstn       = 1'b0;
      clr        = 1'b0;
      acc_done   = 1'b0;
      out_ready  = 1'b0;
      acc_result = '0;
      bias_data  = '0;
      model_reset();
      #2;
      test_reset();
      test_arith();
      test_stream();
      test_back_pressure();
      test_clr();
      test_full_pushpop();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
